// File: rtl/mux4to1_pkg.sv
// Shared select encoding for the mux4to1 word selector.
// Optional parity output is enabled by defining MUX4TO1_PARITY_EN.
package mux4to1_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_A = 2'b00;
   localparam sel_t SEL_B = 2'b01;
   localparam sel_t SEL_C = 2'b10;
   localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux4to1_sel.sv
// Purely combinational 4:1 word selector; every select code maps to an input.
module mux4to1_sel
   import mux4to1_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  sel_t             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] word
);

   // All four codes are covered, so there is no fallback value.
   always_comb begin
      case (sel)
         SEL_A: word = a;
         SEL_B: word = b;
         SEL_C: word = c;
         SEL_D: word = d;
      endcase
   end

endmodule

// File: rtl/mux4to1.sv
// Registered 4:1 word selector with valid tracking (1-cycle latency).
// Define MUX4TO1_PARITY_EN to add the registered even-parity output E_par.
module mux4to1
   import mux4to1_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  sel_t             Sel,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] E,
`ifdef MUX4TO1_PARITY_EN
   output logic             E_par,
`endif
   output logic             out_valid
);

   logic [WIDTH-1:0] word;

   mux4to1_sel #(.WIDTH(WIDTH)) u_sel (
      .sel  (Sel),
      .a    (A),
      .b    (B),
      .c    (C),
      .d    (D),
      .word (word)
   );

   // Valid-only flow, no backpressure: a cycle with in_valid=1 is always
   // accepted, and out_valid is high for exactly the cycle after it. With
   // in_valid=0 the data registers hold their previous contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         E         <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            E <= word;
         end
      end
   end

`ifdef MUX4TO1_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         E_par <= 1'b0;
      end else if (in_valid) begin
         E_par <= ^word;
      end
   end
`endif

endmodule

// File: tb/tb_mux4to1.sv
// Directed and random bench for mux4to1 with a scoreboard queue of selected words.
// Checks E_par as well when MUX4TO1_PARITY_EN is defined.
module tb_mux4to1;
   import mux4to1_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [1:0]   sel = 2'b00;
   logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
   logic [W-1:0] e;
   logic         out_valid;
`ifdef MUX4TO1_PARITY_EN
   logic         e_par;
`endif

   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_e = '0;
   logic         m_v = 1'b0;
   int           checks = 0;
   int           errors = 0;

   mux4to1 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .Sel       (sel),
      .A         (a),
      .B         (b),
      .C         (c),
      .D         (d),
      .E         (e),
`ifdef MUX4TO1_PARITY_EN
      .E_par     (e_par),
`endif
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] pa,
                                         input logic [W-1:0] pb, input logic [W-1:0] pc,
                                         input logic [W-1:0] pd);
      if (s == 2'd0) return pa;
      if (s == 2'd1) return pb;
      if (s == 2'd2) return pc;
      return pd;
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock: drive at negedge, predict, then compare 1 time unit after posedge.
   task automatic step(input string tag, input logic r, input logic v, input logic [1:0] s,
                       input logic [W-1:0] pa, input logic [W-1:0] pb,
                       input logic [W-1:0] pc, input logic [W-1:0] pd);
      @(negedge clk);
      rst = r; in_valid = v; sel = s; a = pa; b = pb; c = pc; d = pd;
      if (v && !r) exp_q.push_back(pick(s, pa, pb, pc, pd));
      @(posedge clk);
      #1;
      if (r) begin
         exp_q.delete();
         m_e = '0;
         m_v = 1'b0;
      end else if (v) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue observed empty expected entry", tag);
         end else begin
            m_e = exp_q.pop_front();
         end
         m_v = 1'b1;
      end else begin
         m_v = 1'b0;
      end
      chk({tag, "_E"}, e, m_e);
      chk({tag, "_vld"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, m_v});
`ifdef MUX4TO1_PARITY_EN
      chk({tag, "_par"}, {{(W-1){1'b0}}, e_par}, {{(W-1){1'b0}}, ^m_e});
`endif
   endtask

   initial begin
      // Reset held two cycles with a valid selection present.
      step("rst0", 1, 1, 2'd0, 1, 2, 3, 4);
      step("rst1", 1, 1, 2'd0, 1, 2, 3, 4);
      step("post_rst", 0, 1, 2'd0, 1, 2, 3, 4);
      chk("post_rst_lit", e, 32'd1);

      // Back-to-back sweep.
      for (int i = 0; i < 4; i++) step("sweep", 0, 1, 2'(i), 1, 2, 3, 4);
      chk("sweep_last_lit", e, 32'd4);

      // Hold while in_valid is low.
      step("hold_c", 0, 1, 2'd2, 1, 2, 3, 4);
      step("hold", 0, 0, 2'd3, 1, 2, 3, 4);
      chk("hold_lit", e, 32'd3);
      step("hold2", 0, 0, 2'd0, 9, 2, 3, 4);
      step("resume", 0, 1, 2'd3, 1, 2, 3, 4);
      chk("resume_lit", e, 32'd4);

      // Full-width patterns.
      for (int i = 0; i < 4; i++)
         step("full", 0, 1, 2'(i), 32'hFFFF_FFFF, 32'h0, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
      chk("full_d_lit", e, 32'h5A5A_5A5A);

      // Mid-stream reset discards the stream.
      step("mid_a", 0, 1, 2'd0, 1, 2, 3, 4);
      step("mid_b", 0, 1, 2'd1, 1, 2, 3, 4);
      step("mid_rst", 1, 1, 2'd2, 1, 2, 3, 4);
      chk("mid_rst_lit", e, 32'd0);
      step("mid_resume", 0, 1, 2'd3, 1, 2, 3, 4);
      chk("mid_resume_lit", e, 32'd4);

      // Parity-relevant words.
      step("par_c", 0, 1, 2'd2, 0, 0, 32'h7, 32'h3);
      step("par_d", 0, 1, 2'd3, 0, 0, 32'h7, 32'h3);

      // Random traffic with occasional reset.
      for (int i = 0; i < 60; i++) begin
         step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux4to1.md
Name: mux4to1

Overview:
- 4-input, WIDTH-bit word selector with a registered output.
- 2-bit Sel picks one of A/B/C/D and drives E one clock later, qualified by a valid flag.
- Used in datapath operand selection (e.g. ALU/writeback source select).
- Synchronous, single clock domain.

Parameters:
- WIDTH, 32, bit width of each data input and of E.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies Sel/A/B/C/D in the current cycle.
- Sel  input  2  select code: 00=A, 01=B, 10=C, 11=D.
- A  input  WIDTH  data input 0.
- B  input  WIDTH  data input 1.
- C  input  WIDTH  data input 2.
- D  input  WIDTH  data input 3.
- E  output  WIDTH  selected data, registered.
- out_valid  output  1  E updated from a valid selection in the previous cycle.

Interface is already decided as: one clock; reset is synchronous and active-high.

Behaviour:
- Reset: on a rising clk edge with rst=1, E <= 0 and out_valid <= 0. Reset overrides in_valid in the same cycle.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on E after edge N.
- Selection at an edge with rst=0 and in_valid=1:
  - E <= A when Sel=00, B when 01, C when 10, D when 11.
  - out_valid <= 1.
- Hold at an edge with rst=0 and in_valid=0:
  - E keeps its previous value (no update, no clearing).
  - out_valid <= 0.
- Sel is fully decoded. No illegal codes, no default-to-zero path in the mux.
- Data passes through bit-exact. No arithmetic, sign extension or truncation; all four inputs and E are WIDTH bits.
- X on Sel while in_valid=1 propagates per simulator semantics; no special handling is required.
- Back-to-back: a new selection every cycle is accepted. E tracks inputs with 1-cycle delay and out_valid stays high.
- Reset mid-stream: the pending result is discarded. The first valid result after reset deassertion appears one cycle after the first in_valid=1 edge.
- No internal state besides the E and out_valid registers (plus the parity register when the optional feature is enabled).

Optional Feature:
- Macro: MUX4TO1_PARITY_EN.
- When defined:
  - Adds output port E_par (1 bit), the even parity (XOR reduction) of the selected word.
  - E_par is registered alongside E with the same reset (0), hold and latency rules.
- When undefined: the E_par port and its register do not exist; all other behaviour is unchanged.

Decomposition:
- Shared package mux4to1_pkg:
  - localparams SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
  - typedef sel_t (2-bit) for the Sel encoding.
- One natural sub-module, mux4to1_sel: the purely combinational 4:1 word selector (Sel, A–D -> selected word).
- The top level adds the output registers, valid tracking and the optional parity.

Test Plan:
- Reset: rst=1 for 2 cycles with A=1,B=2,C=3,D=4,Sel=00,in_valid=1 -> E=0, out_valid=0 throughout; after rst=0, next edge gives E=1, out_valid=1.
- Sweep: A=1,B=2,C=3,D=4, in_valid=1, Sel=00,01,10,11 on consecutive cycles -> E=1,2,3,4 each one cycle after its Sel, out_valid=1 continuously.
- Hold: after E=3 (Sel=10), drop in_valid and change Sel=11, D=4 -> E stays 3, out_valid=0; reassert in_valid -> E=4 next cycle.
- Full width: A=32'hFFFFFFFF, B=0, C=32'hA5A5A5A5, D=32'h5A5A5A5A, sweep Sel -> E bit-exact equal to the selected input.
- Mid-stream reset: sweep running with E=2; assert rst one cycle -> E=0, out_valid=0 next edge; resume Sel=11 with D=4 -> E=4 one cycle after rst deasserts.
- MUX4TO1_PARITY_EN build: Sel=10, C=32'h00000007 -> E=7, E_par=1; Sel=11, D=32'h00000003 -> E_par=0. After reset E_par=0.
